heartbeat_watchdog: RTL and testbench

Downstream consumer of the periodic `tick` from the funcmon interval timer. It monitors an asynchronous heartbeat from the function under test and counts timer ticks since the last heartbeat rising edge. It raises `warning` and then a sticky `alarm` when the heartbeat stops, and keeps a saturating count of missed-heartbeat events for status readout.

---
 rtl/heartbeat_watchdog_pkg.sv | 15 +
 rtl/heartbeat_watchdog_sync.sv | 27 ++
 rtl/heartbeat_watchdog.sv | 106 ++++++++++
 tb/tb_heartbeat_watchdog.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heartbeat_watchdog_pkg.sv
// Shared definitions for the heartbeat watchdog: FSM encodings and default timing constants.
package heartbeat_watchdog_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED   = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_ARMED      = 2'd2,
    ST_ALARM      = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT_TICKS = 5;
  localparam int DEF_WARN_TICKS    = 3;
  localparam int DEF_MISS_W        = 8;

endpackage

// File: rtl/heartbeat_watchdog_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-clock pulse on each synchronized rising edge.
module sync_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/heartbeat_watchdog.sv
// Heartbeat watchdog: counts timer ticks since the last heartbeat edge, warns when late and
// raises a sticky alarm on timeout while keeping a saturating count of timeouts.
//
// state         | meaning
// ST_DISARMED   | monitoring off, counter and flags cleared
// ST_WAIT_FIRST | enabled, waiting for the first heartbeat, ticks ignored
// ST_ARMED      | counting ticks since the last heartbeat
// ST_ALARM      | timed out; sticky until clear or disable
module heartbeat_watchdog
  import heartbeat_watchdog_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int WARN_TICKS    = DEF_WARN_TICKS,
  parameter int MISS_W        = DEF_MISS_W,
  localparam int CW           = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              tick,
  input  logic              heartbeat,
  input  logic              clear,
  output logic              alarm,
  output logic              warning,
  output logic [1:0]        state,
  output logic [CW-1:0]     ticks_since_hb,
  output logic [MISS_W-1:0] missed_count
);

  if (TIMEOUT_TICKS < 2 || WARN_TICKS < 1 || WARN_TICKS >= TIMEOUT_TICKS) begin : g_bad_params
    $error("heartbeat_watchdog: need TIMEOUT_TICKS >= 2 and 1 <= WARN_TICKS < TIMEOUT_TICKS");
  end

  localparam logic [CW-1:0]     TIMEOUT_C = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0]     WARN_C    = CW'(WARN_TICKS);
  localparam logic [MISS_W-1:0] MISS_MAX  = '1;

  state_t        fsm;
  logic          hb_event;
  logic [CW-1:0] cnt_inc;

  sync_rise_detect u_hb_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (heartbeat),
    .rise     (hb_event)
  );

  assign cnt_inc = ticks_since_hb + CW'(1);
  assign state   = fsm;

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm            <= ST_DISARMED;
      ticks_since_hb <= '0;
      alarm          <= 1'b0;
      warning        <= 1'b0;
      missed_count   <= '0;
    end else if (!enable) begin
      // missed_count is deliberately kept across a disable for status readout
      fsm            <= ST_DISARMED;
      ticks_since_hb <= '0;
      alarm          <= 1'b0;
      warning        <= 1'b0;
    end else begin
      case (fsm)
        ST_DISARMED: begin
          fsm            <= ST_WAIT_FIRST;
          ticks_since_hb <= '0;
          warning        <= 1'b0;
        end
        ST_WAIT_FIRST: begin
          ticks_since_hb <= '0;
          warning        <= 1'b0;
          if (hb_event) fsm <= ST_ARMED;
        end
        ST_ARMED: begin
          if (hb_event) begin
            ticks_since_hb <= '0;
            warning        <= 1'b0;
          end else if (tick) begin
            ticks_since_hb <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              fsm     <= ST_ALARM;
              alarm   <= 1'b1;
              warning <= 1'b0;
              if (missed_count != MISS_MAX) missed_count <= missed_count + MISS_W'(1);
            end else begin
              warning <= (cnt_inc >= WARN_C);
            end
          end
        end
        ST_ALARM: begin
          if (clear) begin
            fsm            <= ST_WAIT_FIRST;
            ticks_since_hb <= '0;
            alarm          <= 1'b0;
            warning        <= 1'b0;
          end
        end
        default: fsm <= ST_DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_heartbeat_watchdog.sv
// Directed self-checking bench for heartbeat_watchdog, including a MISS_W=2 instance for saturation.
module tb_heartbeat_watchdog;

  logic       clock;
  logic       reset;
  logic       enable, tick, heartbeat, clear;
  logic       alarm, warning;
  logic [1:0] state;
  logic [2:0] ticks_since_hb;
  logic [7:0] missed_count;

  logic       enable2, tick2, hb2, clear2;
  logic       alarm2, warning2;
  logic [1:0] state2;
  logic [2:0] ticks2;
  logic [1:0] missed2;

  int total = 0;
  int bad   = 0;

  heartbeat_watchdog dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .tick           (tick),
    .heartbeat      (heartbeat),
    .clear          (clear),
    .alarm          (alarm),
    .warning        (warning),
    .state          (state),
    .ticks_since_hb (ticks_since_hb),
    .missed_count   (missed_count)
  );

  heartbeat_watchdog #(.MISS_W(2)) dut_sat (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable2),
    .tick           (tick2),
    .heartbeat      (hb2),
    .clear          (clear2),
    .alarm          (alarm2),
    .warning        (warning2),
    .state          (state2),
    .ticks_since_hb (ticks2),
    .missed_count   (missed2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  // heartbeat held 2 clocks; the event is consumed at the third edge
  task automatic pulse_hb();
    heartbeat = 1'b1;
    step();
    step();
    heartbeat = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_hb2();
    hb2 = 1'b1;
    step();
    step();
    hb2 = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      total++;
      if (state !== 2'd0 || alarm !== 1'b0 || warning !== 1'b0 ||
          ticks_since_hb !== 3'd0 || missed_count !== 8'd0 || state2 !== 2'd0) begin
        bad++;
        $display("FAIL reset_idle: state=%0d alarm=%0b warn=%0b cnt=%0d missed=%0d, required all 0",
                 state, alarm, warning, ticks_since_hb, missed_count);
      end
    end
    reset = 1'b0;
    step();
    tick = 1'b0;
    step();
    total++;
    if (state !== 2'd0 || alarm !== 1'b0 || warning !== 1'b0 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL idle_disabled: state=%0d alarm=%0b warn=%0b cnt=%0d, required all 0",
               state, alarm, warning, ticks_since_hb);
    end
  endtask

  task automatic test_healthy();
    enable = 1'b1;
    step();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL enable_wait_first: state=%0d required 1", state);
    end
    do_tick();
    total++;
    if (state !== 2'd1 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL wait_first_ignores_tick: state=%0d cnt=%0d required 1/0", state, ticks_since_hb);
    end
    pulse_hb();
    total++;
    if (state !== 2'd2 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL first_hb_arms: state=%0d cnt=%0d required 2/0", state, ticks_since_hb);
    end
    for (int t = 0; t < 50; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick = (c == 0);
        heartbeat = ((t % 2) == 0) && (c < 2);
        step();
        total++;
        if (state !== 2'd2 || ticks_since_hb > 3'd2 || warning !== 1'b0 || alarm !== 1'b0) begin
          bad++;
          $display("FAIL healthy t=%0d c=%0d: state=%0d cnt=%0d warn=%0b alarm=%0b required 2/<=2/0/0",
                   t, c, state, ticks_since_hb, warning, alarm);
        end
      end
    end
    tick = 1'b0;
    heartbeat = 1'b0;
  endtask

  task automatic test_warn_alarm();
    logic [2:0] exp_cnt [5];
    logic       exp_warn[5];
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    exp_warn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    pulse_hb();
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      total++;
      if (ticks_since_hb !== exp_cnt[k] || warning !== exp_warn[k] || alarm !== (k == 4)) begin
        bad++;
        $display("FAIL warn_alarm tick%0d: cnt=%0d warn=%0b alarm=%0b required %0d/%0b/%0b",
                 k + 1, ticks_since_hb, warning, alarm, exp_cnt[k], exp_warn[k], (k == 4));
      end
      step();
    end
    total++;
    if (state !== 2'd3 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL alarm_state: state=%0d missed=%0d required 3/1", state, missed_count);
    end
    pulse_hb();
    do_tick();
    total++;
    if (alarm !== 1'b1 || state !== 2'd3 || ticks_since_hb !== 3'd5) begin
      bad++;
      $display("FAIL alarm_sticky: alarm=%0b state=%0d cnt=%0d required 1/3/5", alarm, state, ticks_since_hb);
    end
  endtask

  task automatic test_simultaneous();
    clear = 1'b1;
    heartbeat = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if (state !== 2'd1 || alarm !== 1'b0 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL clear_to_wait: state=%0d alarm=%0b cnt=%0d required 1/0/0", state, alarm, ticks_since_hb);
    end
    step();
    heartbeat = 1'b0;
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL clear_hb_latency: state=%0d required 1", state);
    end
    step();
    total++;
    if (state !== 2'd2 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL clear_hb_arm: state=%0d cnt=%0d required 2/0", state, ticks_since_hb);
    end
    do_tick();
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if (state !== 2'd2 || ticks_since_hb !== 3'd1 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL clear_outside_alarm: state=%0d cnt=%0d alarm=%0b required 2/1/0", state, ticks_since_hb, alarm);
    end
    do_tick();
    do_tick();
    do_tick();
    total++;
    if (ticks_since_hb !== 3'd4 || warning !== 1'b1) begin
      bad++;
      $display("FAIL pre_coincide: cnt=%0d warn=%0b required 4/1", ticks_since_hb, warning);
    end
    heartbeat = 1'b1;
    step();
    step();
    heartbeat = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    total++;
    if (ticks_since_hb !== 3'd0 || state !== 2'd2 || alarm !== 1'b0 || warning !== 1'b0 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL hb_wins_tick5: cnt=%0d state=%0d alarm=%0b warn=%0b missed=%0d required 0/2/0/0/1",
               ticks_since_hb, state, alarm, warning, missed_count);
    end
    step();
  endtask

  task automatic test_disable();
    for (int k = 0; k < 4; k++) do_tick();
    total++;
    if (ticks_since_hb !== 3'd4 || warning !== 1'b1 || state !== 2'd2) begin
      bad++;
      $display("FAIL pre_disable: cnt=%0d warn=%0b state=%0d required 4/1/2", ticks_since_hb, warning, state);
    end
    enable = 1'b0;
    step();
    total++;
    if (state !== 2'd0 || ticks_since_hb !== 3'd0 || warning !== 1'b0 || alarm !== 1'b0 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL disable: state=%0d cnt=%0d warn=%0b alarm=%0b missed=%0d required 0/0/0/0/1",
               state, ticks_since_hb, warning, alarm, missed_count);
    end
    enable = 1'b1;
    step();
    do_tick();
    total++;
    if (state !== 2'd1 || ticks_since_hb !== 3'd0) begin
      bad++;
      $display("FAIL reenable: state=%0d cnt=%0d required 1/0", state, ticks_since_hb);
    end
    pulse_hb();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    enable2 = 1'b1;
    step();
    pulse_hb2();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) begin
        tick2 = 1'b1;
        step();
        tick2 = 1'b0;
        step();
      end
      total++;
      if (alarm2 !== 1'b1 || missed2 !== exp_sat[i]) begin
        bad++;
        $display("FAIL saturation #%0d: alarm=%0b missed=%0d required 1/%0d", i + 1, alarm2, missed2, exp_sat[i]);
      end
      clear2 = 1'b1;
      step();
      clear2 = 1'b0;
      pulse_hb2();
    end
    enable2 = 1'b0;
    step();
  endtask

  task automatic test_short_pulse_reset();
    do_tick();
    do_tick();
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    for (int i = 0; i < 4; i++) step();
    do_tick();
    do_tick();
    total++;
    if (ticks_since_hb !== 3'd2 && ticks_since_hb !== 3'd4) begin
      bad++;
      $display("FAIL short_pulse: cnt=%0d required 2 (counted once) or 4 (ignored)", ticks_since_hb);
    end
    for (int k = 0; k < 3; k++) do_tick();
    total++;
    if (alarm !== 1'b1 || state !== 2'd3 || missed_count !== 8'd2) begin
      bad++;
      $display("FAIL second_alarm: alarm=%0b state=%0d missed=%0d required 1/3/2", alarm, state, missed_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (state !== 2'd0 || alarm !== 1'b0 || warning !== 1'b0 || ticks_since_hb !== 3'd0 || missed_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_alarm: state=%0d alarm=%0b warn=%0b cnt=%0d missed=%0d required all 0",
               state, alarm, warning, ticks_since_hb, missed_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    tick = 1'b0;
    heartbeat = 1'b0;
    clear = 1'b0;
    enable2 = 1'b0;
    tick2 = 1'b0;
    hb2 = 1'b0;
    clear2 = 1'b0;
    @(negedge clock);
    test_reset();
    test_healthy();
    test_warn_alarm();
    test_simultaneous();
    test_disable();
    test_saturation();
    test_short_pulse_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
